// File: rtl/port_alloc_pkg.sv
// rtl/port_alloc_pkg.sv - shared router parameters and types for port allocation
package port_alloc_pkg;

    localparam int NUM_PORT = 5;
    localparam int PRIO_W   = 3;
    localparam int VEC_W    = NUM_PORT * NUM_PORT;

    localparam logic [PRIO_W:0] NUM_PORT_S = (PRIO_W + 1)'(NUM_PORT);

    typedef logic [NUM_PORT-1:0] port_mask_t;
    typedef logic [PRIO_W-1:0]   prio_t;

    // Modulo-NUM_PORT add; both operands are assumed to already be in range.
    function automatic prio_t wrap_add(prio_t base, prio_t ofs);
        logic [PRIO_W:0] sum;
        sum = {1'b0, base} + {1'b0, ofs};
        if (sum >= NUM_PORT_S) begin
            sum = sum - NUM_PORT_S;
        end
        return sum[PRIO_W-1:0];
    endfunction

endpackage

// File: rtl/port_alloc_slice.sv
// rtl/port_alloc_slice.sv - one greedy grant step: lowest free requested output
module port_alloc_slice
    import port_alloc_pkg::*;
(
    input  port_mask_t req,
    input  port_mask_t taken_in,
    output port_mask_t grant,
    output port_mask_t taken_out
);

    port_mask_t avail;

    assign avail     = req & ~taken_in;
    // Isolate the lowest set bit of the still-available requests.
    assign grant     = avail & (~avail + port_mask_t'(1));
    assign taken_out = taken_in | grant;

endmodule

// File: rtl/port_alloc_wrapper.sv
// rtl/port_alloc_wrapper.sv - rotating-priority greedy allocator built from a slice chain
module port_alloc_wrapper
    import port_alloc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [VEC_W-1:0] reqVector,
    output logic [VEC_W-1:0] allocVector
);

    prio_t                          prio;
    logic [NUM_PORT-1:0][NUM_PORT-1:0] chain_req;
    logic [NUM_PORT-1:0][NUM_PORT-1:0] chain_grant;
    logic [NUM_PORT:0][NUM_PORT-1:0]   taken;
    logic                           any_grant;

    assign taken[0] = '0;

    // Chain position k serves input (prio + k) mod NUM_PORT.
    always_comb begin
        chain_req = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            chain_req[k] = reqVector[int'(wrap_add(prio, prio_t'(k)))*NUM_PORT +: NUM_PORT];
        end
    end

    for (genvar k = 0; k < NUM_PORT; k++) begin : g_slice
        port_alloc_slice u_slice (
            .req       (chain_req[k]),
            .taken_in  (taken[k]),
            .grant     (chain_grant[k]),
            .taken_out (taken[k+1])
        );
    end

    always_comb begin
        allocVector = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            allocVector[int'(wrap_add(prio, prio_t'(k)))*NUM_PORT +: NUM_PORT] = chain_grant[k];
        end
    end

    assign any_grant = |allocVector;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= '0;
        end else if (any_grant) begin
            prio <= wrap_add(prio, prio_t'(1));
        end
    end

endmodule

// File: tb/tb_port_alloc_wrapper.sv
// tb/tb_port_alloc_wrapper.sv - scoreboard bench for the rotating port allocator
module tb_port_alloc_wrapper;

    logic        clk;
    logic        reset;
    logic [24:0] reqVector;
    logic [24:0] allocVector;

    port_alloc_wrapper dut (
        .clk         (clk),
        .reset       (reset),
        .reqVector   (reqVector),
        .allocVector (allocVector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          step;
        logic [24:0] req;
        logic [24:0] alloc;
        logic [2:0]  prio;
        bit          chk_alloc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [24:0] pk(logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                                       logic [4:0] a3, logic [4:0] a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    // All inputs requesting everything: the k-th served input gets output k.
    function automatic logic [24:0] rot_all(int p);
        logic [24:0] v;
        logic [4:0]  one;
        v   = '0;
        one = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            v[i*5 +: 5] = one << ((i - p + 5) % 5);
        end
        return v;
    endfunction

    task automatic apply(input int step, input logic rst, input logic [24:0] req,
                         input logic [24:0] alloc, input logic [2:0] prio, input bit chk_alloc);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        reqVector = req;
        e.step = step; e.req = req; e.alloc = alloc; e.prio = prio; e.chk_alloc = chk_alloc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [4:0]  a;
        logic [4:0]  r;
        logic [4:0]  used;
        bit          bad_hot;
        bit          bad_sub;
        bit          bad_dup;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_alloc) begin
                tests++;
                if (allocVector !== e.alloc) begin
                    fails++;
                    $display("FAIL alloc step %0d: got %h required %h", e.step, allocVector, e.alloc);
                end
            end
            tests++;
            if (dut.prio !== e.prio) begin
                fails++;
                $display("FAIL prio step %0d: got %0d required %0d", e.step, dut.prio, e.prio);
            end
            bad_hot = 0; bad_sub = 0; bad_dup = 0; used = '0;
            for (int i = 0; i < 5; i++) begin
                a = allocVector[i*5 +: 5];
                r = e.req[i*5 +: 5];
                if ((a & (a - 5'd1)) != 5'd0) bad_hot = 1;
                if ((a & ~r) != 5'd0)         bad_sub = 1;
                if ((a & used) != 5'd0)       bad_dup = 1;
                used = used | a;
            end
            tests += 3;
            if (bad_hot) begin fails++; $display("FAIL onehot step %0d: alloc %h", e.step, allocVector); end
            if (bad_sub) begin fails++; $display("FAIL subset step %0d: alloc %h req %h", e.step, allocVector, e.req); end
            if (bad_dup) begin fails++; $display("FAIL unique step %0d: alloc %h", e.step, allocVector); end
        end
    end

    localparam logic [4:0] Z = 5'b00000;

    initial begin
        logic [24:0] r26, a26, a28, r27, a27, o4, r;
        logic [2:0]  p;
        r26 = pk(5'b00001, 5'b00001, 5'b01000, 5'b10000, 5'b00100);
        a26 = pk(5'b00001, Z,        5'b01000, 5'b10000, 5'b00100);
        a28 = pk(Z,        5'b00001, 5'b01000, 5'b10000, 5'b00100);
        r27 = pk(5'b00001, 5'b00001, 5'b01000, 5'b10000, 5'b01000);
        a27 = pk(5'b00001, Z,        5'b01000, 5'b10000, Z);
        o4  = pk(5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000);

        reset     = 1'b1;
        reqVector = '0;
        @(posedge clk);

        apply(1,  1, '0,           '0,          3'd0, 1);
        apply(2,  1, r26,          a26,         3'd0, 1);
        apply(3,  1, r27,          a27,         3'd0, 1);
        apply(4,  0, r26,          a26,         3'd0, 1);
        apply(5,  0, r26,          a28,         3'd1, 1);
        apply(6,  0, {25{1'b1}},   rot_all(2),  3'd2, 1);
        apply(7,  0, {25{1'b1}},   rot_all(3),  3'd3, 1);
        apply(8,  0, {25{1'b1}},   rot_all(4),  3'd4, 1);
        apply(9,  0, {25{1'b1}},   rot_all(0),  3'd0, 1);
        apply(10, 0, {25{1'b1}},   rot_all(1),  3'd1, 1);
        apply(11, 0, '0,           '0,          3'd2, 1);
        apply(12, 0, '0,           '0,          3'd2, 1);
        apply(13, 0, {25{1'b1}},   rot_all(2),  3'd2, 1);
        apply(14, 1, {25{1'b1}},   rot_all(3),  3'd3, 1);
        apply(15, 1, pk(5'b00011, 5'b00001, Z, Z, Z), pk(5'b00001, Z, Z, Z, Z), 3'd0, 1);
        apply(16, 1, o4,           pk(5'b10000, Z, Z, Z, Z), 3'd0, 1);
        apply(17, 0, o4,           pk(5'b10000, Z, Z, Z, Z), 3'd0, 1);
        apply(18, 0, o4,           pk(Z, 5'b10000, Z, Z, Z), 3'd1, 1);

        p = 3'd2;
        for (int n = 0; n < 200; n++) begin
            r = 25'($urandom) & 25'($urandom) & 25'($urandom);
            if (n % 7 == 0) r = '0;
            apply(100 + n, 0, r, '0, p, 0);
            if (r != '0) p = (p == 3'd4) ? 3'd0 : p + 3'd1;
        end

        @(posedge clk);
        #1;
        reqVector = '0;
        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
